// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse controller.
package efuse_pkg;

  localparam int          DW             = 8;
  localparam logic [15:0] EFUSE_PASSWORD = 16'h55AA;

  typedef enum logic [1:0] {
    MODE_RD   = 2'b00,
    MODE_WR   = 2'b01,
    MODE_AL   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SETUP, S_RD_STROBE, S_RD_CAP,
    S_PG_SKIP, S_PG_SETUP, S_PG_STROBE, S_PG_HOLD, S_DONE
  } state_e;

  // What the current read sequence is for; decides where captured bytes go.
  typedef enum logic [1:0] {PH_RD, PH_AL, PH_BLANK, PH_VERIFY} phase_e;

  function automatic logic is_rd_state(state_e s);
    return (s == S_RD_SETUP) || (s == S_RD_STROBE) || (s == S_RD_CAP);
  endfunction

  function automatic logic is_pg_state(state_e s);
    return (s == S_PG_SETUP) || (s == S_PG_STROBE) || (s == S_PG_HOLD);
  endfunction

endpackage

// File: rtl/efuse_strobe_gen.sv
// Loadable down-counter timing the aen window; shared by read and program strobes.
module efuse_strobe_gen #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] width,
  input  logic          en,
  output logic          last
);

  logic [CW-1:0] cnt;

  // Load the window on the setup cycle (0 behaves as 1), count down while strobing.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= (width == '0) ? CW'(1) : width;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign last = (cnt <= CW'(1));

endmodule

// File: rtl/efuse_ctrl_mc.sv
// eFuse controller: autoload, word read, password-gated word program, blank check.
// Optional readback after programming is compiled in with EFUSE_VERIFY_EN.
module efuse_ctrl_mc
  import efuse_pkg::*;
#(
  parameter int EFUSE_BITS = 256,
  parameter int NW         = 64,
  parameter int NR         = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pmu_efuse_start,
  input  logic                               rg_efuse_start,
  input  logic [1:0]                         rg_efuse_mode,
  input  logic [15:0]                        rg_efuse_password,
  input  logic                               rg_efuse_blank_en,
  input  logic [NW-1:0]                      rg_efuse_wdata,
  input  logic [$clog2(EFUSE_BITS/NW)-1:0]   rg_efuse_write_sel,
  input  logic [$clog2(EFUSE_BITS/NR)-1:0]   rg_efuse_read_sel,
  input  logic [5:0]                         rg_efuse_trd,
  input  logic [9:0]                         rg_efuse_tpgm,
  input  logic [DW-1:0]                      efuse_rdata_i,
  output logic                               efuse_pgmen_o,
  output logic                               efuse_rden_o,
  output logic                               efuse_aen_o,
  output logic [$clog2(EFUSE_BITS)-1:0]      efuse_addr_o,
  output logic [NR-1:0]                      rg_efuse_rdata,
  output logic [EFUSE_BITS-1:0]              autoload_data,
  output logic                               efuse_autoload_done,
  output logic                               efuse_autoload_vld,
  output logic                               op_done,
  output logic                               err_pwd,
  output logic                               no_blank,
  output logic                               verify_err,
  output logic                               efuse_busy
);

  localparam int AW  = $clog2(EFUSE_BITS);
  localparam int WSW = $clog2(EFUSE_BITS/NW);
  localparam int RSW = $clog2(EFUSE_BITS/NR);
  localparam int BIW = $clog2(NW);
  localparam int BYW = $clog2(EFUSE_BITS/DW);

  typedef struct packed {
    logic           src_rg;
    mode_e          mode;
    logic [NW-1:0]  wdata;
    logic [WSW-1:0] wsel;
    logic [RSW-1:0] rsel;
    logic [5:0]     trd;
    logic [9:0]     tpgm;
  } req_t;

  state_e                  state, state_n;
  phase_e                  phase, phase_n;
  req_t                    req, req_n;
  logic [BYW-1:0]          byte_idx, byte_n, byte_last;
  logic [BIW-1:0]          bit_idx, bit_n;
  logic [EFUSE_BITS-1:0]   rbuf, rbuf_n;
  logic [AW-1:0]           addr_n;
  logic                    accept, bad_pwd, blank_hit, strb_last;
  int                      rd_base;

  efuse_strobe_gen #(.CW(10)) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .load  ((state == S_RD_SETUP) || (state == S_PG_SETUP)),
    .width ((state == S_RD_SETUP) ? 10'(req.trd) : req.tpgm),
    .en    ((state == S_RD_STROBE) || (state == S_PG_STROBE)),
    .last  (strb_last)
  );

  // Byte count of the running read sequence, minus one.
  always_comb begin
    case (phase)
      PH_AL:   byte_last = BYW'(EFUSE_BITS/DW - 1);
      PH_RD:   byte_last = BYW'(NR/DW - 1);
      default: byte_last = BYW'(NW/DW - 1);
    endcase
  end

  // Next-state, request latch, counters and capture buffer.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    req_n     = req;
    byte_n    = byte_idx;
    bit_n     = bit_idx;
    rbuf_n    = rbuf;
    accept    = 1'b0;
    bad_pwd   = 1'b0;
    blank_hit = 1'b0;
    if (state == S_RD_CAP) rbuf_n[int'(byte_idx)*DW +: DW] = efuse_rdata_i;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (pmu_efuse_start || rg_efuse_start) begin
          accept       = 1'b1;
          req_n.src_rg = !pmu_efuse_start;
          req_n.mode   = pmu_efuse_start ? MODE_AL : mode_e'(rg_efuse_mode);
          req_n.wdata  = rg_efuse_wdata;
          req_n.wsel   = rg_efuse_write_sel;
          req_n.rsel   = rg_efuse_read_sel;
          req_n.trd    = rg_efuse_trd;
          req_n.tpgm   = rg_efuse_tpgm;
          byte_n       = '0;
          bit_n        = '0;
          case (req_n.mode)
            MODE_RD: begin phase_n = PH_RD; state_n = S_RD_SETUP; end
            MODE_AL: begin phase_n = PH_AL; state_n = S_RD_SETUP; end
            MODE_WR: begin
              if (rg_efuse_password != EFUSE_PASSWORD) begin
                bad_pwd = 1'b1;
                state_n = S_DONE;
              end else if (rg_efuse_blank_en) begin
                phase_n = PH_BLANK;
                state_n = S_RD_SETUP;
              end else begin
                state_n = rg_efuse_wdata[0] ? S_PG_SETUP : S_PG_SKIP;
              end
            end
            default: state_n = S_DONE;
          endcase
        end
      end
      S_RD_SETUP:  state_n = S_RD_STROBE;
      S_RD_STROBE: if (strb_last) state_n = S_RD_CAP;
      S_RD_CAP: begin
        if (phase == PH_BLANK && efuse_rdata_i != '0) begin
          blank_hit = 1'b1;
          state_n   = S_DONE;
        end else if (byte_idx != byte_last) begin
          byte_n  = byte_idx + 1'b1;
          state_n = S_RD_SETUP;
        end else if (phase == PH_BLANK) begin
          bit_n   = '0;
          state_n = req.wdata[0] ? S_PG_SETUP : S_PG_SKIP;
        end else begin
          state_n = S_DONE;
        end
      end
      S_PG_SETUP:  state_n = S_PG_STROBE;
      S_PG_STROBE: if (strb_last) state_n = S_PG_HOLD;
      S_PG_SKIP, S_PG_HOLD: begin
        if (bit_idx != BIW'(NW-1)) begin
          bit_n   = bit_idx + 1'b1;
          state_n = req.wdata[bit_n] ? S_PG_SETUP : S_PG_SKIP;
        end else begin
`ifdef EFUSE_VERIFY_EN
          phase_n = PH_VERIFY;
          byte_n  = '0;
          state_n = S_RD_SETUP;
`else
          state_n = S_DONE;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Macro address for the upcoming cycle: byte index on reads, bit index on programs.
  always_comb begin
    case (phase_n)
      PH_AL:   rd_base = 0;
      PH_RD:   rd_base = int'(req_n.rsel) * (NR/DW);
      default: rd_base = int'(req_n.wsel) * (NW/DW);
    endcase
    if (is_rd_state(state_n))      addr_n = AW'(rd_base + int'(byte_n));
    else if (is_pg_state(state_n)) addr_n = AW'(int'(req_n.wsel) * NW + int'(bit_n));
    else                           addr_n = efuse_addr_o;
  end

  // State, datapath and registered outputs; results land only when an op completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      phase               <= PH_RD;
      req                 <= '0;
      byte_idx            <= '0;
      bit_idx             <= '0;
      rbuf                <= '0;
      efuse_pgmen_o       <= 1'b0;
      efuse_rden_o        <= 1'b0;
      efuse_aen_o         <= 1'b0;
      efuse_addr_o        <= '0;
      rg_efuse_rdata      <= '0;
      autoload_data       <= '0;
      efuse_autoload_done <= 1'b0;
      efuse_autoload_vld  <= 1'b0;
      op_done             <= 1'b0;
      err_pwd             <= 1'b0;
      no_blank            <= 1'b0;
      efuse_busy          <= 1'b0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      req           <= req_n;
      byte_idx      <= byte_n;
      bit_idx       <= bit_n;
      rbuf          <= rbuf_n;
      efuse_rden_o  <= is_rd_state(state_n);
      efuse_pgmen_o <= is_pg_state(state_n);
      efuse_aen_o   <= (state_n == S_RD_STROBE) || (state_n == S_PG_STROBE);
      efuse_addr_o  <= addr_n;
      efuse_busy    <= (state_n != S_IDLE) && (state_n != S_DONE);
      op_done       <= (state_n == S_DONE) && req_n.src_rg;
      efuse_autoload_vld <= 1'b0;
      if (accept) begin
        err_pwd  <= bad_pwd;
        no_blank <= 1'b0;
      end
      if (blank_hit) no_blank <= 1'b1;
      if (state == S_RD_CAP && state_n == S_DONE) begin
        if (phase == PH_AL) begin
          autoload_data       <= rbuf_n;
          efuse_autoload_vld  <= 1'b1;
          efuse_autoload_done <= 1'b1;
        end
        if (phase == PH_RD) rg_efuse_rdata <= rbuf_n[NR-1:0];
      end
    end
  end

`ifdef EFUSE_VERIFY_EN
  // Readback must show every fuse that was asked to burn.
  always_ff @(posedge clk) begin
    if (rst || accept)
      verify_err <= 1'b0;
    else if (state == S_RD_CAP && state_n == S_DONE && phase == PH_VERIFY)
      verify_err <= ((rbuf_n[NW-1:0] & req.wdata) != req.wdata);
  end
`else
  assign verify_err = 1'b0;
`endif

endmodule
